dual_count_monitor: RTL and testbench
=====================================

// Module: dual_count_monitor
// PURPOSE
//  Observer for the dual-counter top: consumes the shared enable and both count outputs, tracks the
//  expected count, flags divergence and wrap-around. Reports each event on a one-entry valid/ready
//  event port to a status or logging consumer. Placed beside the counter pair, same clock domain.
// PARAMETERS
//  WIDTH       8   width of q0/q1 and of the internal expected count
//  WRAP_CNT_W  16  width of wrap_count (used only when DCM_WRAP_CNT_EN is defined)
// PORTS
//  clk         in   1           single clock, all logic on posedge
//  reset       in   1           synchronous, active-high reset
//  en          in   1           the same enable driven to both counters
//  q0          in   WIDTH       count output of counter 0
//  q1          in   WIDTH       count output of counter 1
//  clear       in   1           1-cycle pulse: clear sticky flags, resync
//  locked      out  1           1 while in TRACK
//  err         out  1           sticky mismatch flag
//  evt_valid   out  1           event pending
//  evt_ready   in   1           consumer accepts event
//  evt_code    out  3           1=q0 bad, 2=q1 bad, 3=both bad, 4=wrap, 0=none
//  evt_value   out  WIDTH       expected count when the event was detected
//  evt_ovf     out  1           sticky: an event was dropped
//  wrap_count  out  WRAP_CNT_W  saturating count of wraps (tied to 0 without the macro)
// BEHAVIOUR
//  - Reset: state=IDLE, exp=0. All outputs are 0: locked, err, evt_valid, evt_code, evt_value, evt_ovf, wrap_count.
//  - FSM IDLE->SYNC: first cycle after reset deasserts.
//  - SYNC: if q0!=q1, post code 3, set err, go FAULT. Else load exp<=q0+en (mod 2^WIDTH) and go TRACK.
//  - TRACK: each cycle compare q0 and q1 against exp. Then update exp<=exp+en (mod 2^WIDTH).
//  - Counters are registered: q reflects en one edge later. exp therefore models the next-cycle q.
//  - Mismatch in TRACK: post code 1/2/3, set err, go FAULT. locked falls on the same edge.
//  - Latency: a mismatch on q in cycle N gives err/evt_valid high in cycle N+1.
//  - Wrap: in TRACK with exp=all-ones and en=1 and no mismatch, post code 4. exp becomes 0.
//  - Mismatch takes precedence over wrap in the same cycle. The wrap is then not posted or counted.
//  - FAULT: holds until clear. While in FAULT, q0/q1 are ignored and no new events are generated.
//  - clear: in any non-IDLE state, go SYNC next cycle. Zero err, evt_ovf and wrap_count.
//    clear does not flush a pending event.
//  - Event slot:
//    - evt_code/evt_value stay stable while evt_valid=1.
//    - Transfer occurs when evt_valid & evt_ready.
//    - A new event in the same cycle as a transfer is loaded, not dropped.
//    - A new event while valid & !ready is dropped and evt_ovf is set.
//    - evt_ready while evt_valid=0 is ignored.
//  - reset asserted mid-operation: all state returns to reset values on that edge. A pending event is discarded.
// CONFIGURATION
//  DCM_WRAP_CNT_EN defined:
//    - wrap_count increments on each posted wrap (code 4) and saturates at all-ones.
//  DCM_WRAP_CNT_EN undefined:
//    - no wrap counter register; wrap_count is tied to 0.
//    - wrap events are still posted on the event port.
// STRUCTURE
//  - dcm_pkg: typedef enum state_t {IDLE,SYNC,TRACK,FAULT}; typedef enum evt_code_t with the codes above;
//    localparam EVT_W=3.
//  - Sub-module dcm_evt_slot: one-entry valid/ready register holding code+value, with drop/ovf output.
//  - Top holds the FSM, exp register, comparators and the optional wrap counter.
// TESTING
//  - Reset, then q0=q1=5, en=0 -> locked=1 by the 3rd cycle; err=0; evt_valid=0.
//  - Track q0=q1 from 0x10 with en=1 for 20 cycles -> no event, err=0, locked stays 1.
//  - In TRACK force q1 one high for 1 cycle -> next cycle err=1, evt_code=2, locked=0.
//    Later q values are ignored until clear.
//  - Count through 0xFF->0x00 with evt_ready=1 -> one code-4 event with evt_value=0xFF.
//    wrap_count=1 with the macro defined, 0 without it.
//  - Hold evt_ready=0 across two wraps -> the first event is held, evt_ovf=1.
//    Then pulse clear -> evt_ovf=0 and the pending event is still valid.
//  - Assert reset mid-TRACK with an event pending -> all outputs 0 next cycle; resync afterwards.

Source files
------------

// File: rtl/dcm_pkg.sv
// Shared types for the dual-counter monitor: FSM states, event codes and event width.
package dcm_pkg;

    localparam int EVT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef enum logic [EVT_W-1:0] {
        EVT_NONE = 3'd0,
        EVT_Q0   = 3'd1,
        EVT_Q1   = 3'd2,
        EVT_BOTH = 3'd3,
        EVT_WRAP = 3'd4
    } evt_code_t;

endpackage

// File: rtl/dcm_evt_slot.sv
// One-entry valid/ready event register holding code and value; a push that finds the
// slot full and not draining is dropped and latched into the sticky ovf flag.
module dcm_evt_slot
    import dcm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  evt_code_t        push_code,
    input  logic [WIDTH-1:0] push_value,
    input  logic             ready,
    input  logic             clr_ovf,
    output logic             valid,
    output evt_code_t        code,
    output logic [WIDTH-1:0] value,
    output logic             ovf
);

    logic             valid_q, valid_d;
    evt_code_t        code_q, code_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             ovf_q, ovf_d;
    logic             accept_s;
    logic             drop_s;

    // Slot next state: load on push when empty or draining, drop otherwise, release on transfer.
    always_comb begin
        valid_d  = valid_q;
        code_d   = code_q;
        value_d  = value_q;
        accept_s = push & (~valid_q | ready);
        drop_s   = push & valid_q & ~ready;
        if (accept_s) begin
            valid_d = 1'b1;
            code_d  = push_code;
            value_d = push_value;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        ovf_d = clr_ovf ? 1'b0 : (ovf_q | drop_s);
    end

    // Slot registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            code_q  <= EVT_NONE;
            value_q <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid = valid_q;
    assign code  = code_q;
    assign value = value_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/dual_count_monitor.sv
// Observer for a counter pair: tracks the expected count, flags divergence and wrap-around.
// Optional saturating wrap counter enabled by defining DCM_WRAP_CNT_EN.
module dual_count_monitor
    import dcm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int WRAP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [WIDTH-1:0]      q0,
    input  logic [WIDTH-1:0]      q1,
    input  logic                  clear,
    output logic                  locked,
    output logic                  err,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [EVT_W-1:0]      evt_code,
    output logic [WIDTH-1:0]      evt_value,
    output logic                  evt_ovf,
    output logic [WRAP_CNT_W-1:0] wrap_count
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             post_s;
    evt_code_t        post_code_s;
    logic             wrap_s;
    logic             bad0_s, bad1_s;
    logic [WIDTH-1:0] en_ext_s;
    evt_code_t        slot_code_s;

    // FSM, expected-count update and event generation; clear overrides everything but flags.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        err_d       = err_q;
        post_s      = 1'b0;
        post_code_s = EVT_NONE;
        wrap_s      = 1'b0;
        en_ext_s    = {{(WIDTH-1){1'b0}}, en};
        bad0_s      = (q0 != exp_q);
        bad1_s      = (q1 != exp_q);
        case (state_q)
            IDLE: state_d = SYNC;
            SYNC: begin
                if (q0 != q1) begin
                    post_s      = 1'b1;
                    post_code_s = EVT_BOTH;
                    err_d       = 1'b1;
                    state_d     = FAULT;
                end else begin
                    exp_d   = q0 + en_ext_s;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                exp_d = exp_q + en_ext_s;
                if (bad0_s || bad1_s) begin
                    post_s      = 1'b1;
                    post_code_s = evt_code_t'({1'b0, bad1_s, bad0_s});
                    err_d       = 1'b1;
                    state_d     = FAULT;
                end else if (en && (exp_q == {WIDTH{1'b1}})) begin
                    post_s      = 1'b1;
                    post_code_s = EVT_WRAP;
                    wrap_s      = 1'b1;
                end else begin
                    state_d = TRACK;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        if (clear && (state_q != IDLE)) begin
            state_d = SYNC;
            exp_d   = exp_q;
            post_s  = 1'b0;
            wrap_s  = 1'b0;
        end else begin
            post_s = post_s;
        end
        if (clear) begin
            err_d = 1'b0;
        end else begin
            err_d = err_d;
        end
        locked_d = (state_d == TRACK);
    end

    // Monitor state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            exp_q    <= {WIDTH{1'b0}};
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    dcm_evt_slot #(
        .WIDTH (WIDTH)
    ) u_evt_slot (
        .clk        (clk),
        .reset      (reset),
        .push       (post_s),
        .push_code  (post_code_s),
        .push_value (exp_q),
        .ready      (evt_ready),
        .clr_ovf    (clear),
        .valid      (evt_valid),
        .code       (slot_code_s),
        .value      (evt_value),
        .ovf        (evt_ovf)
    );

    assign evt_code = slot_code_s;
    assign locked   = locked_q;
    assign err      = err_q;

`ifdef DCM_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // Saturating count of wraps, zeroed by clear.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (clear) begin
            wrap_cnt_d = {WRAP_CNT_W{1'b0}};
        end else if (wrap_s && (wrap_cnt_q != {WRAP_CNT_W{1'b1}})) begin
            wrap_cnt_d = wrap_cnt_q + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wrap_cnt_d = wrap_cnt_q;
        end
    end

    // Wrap counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt_q <= {WRAP_CNT_W{1'b0}};
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_count = wrap_cnt_q;
`else
    logic unused_wrap_s;
    assign unused_wrap_s = wrap_s;
    assign wrap_count    = {WRAP_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dual_count_monitor.sv
// Bench for dual_count_monitor: directed vector table, hand-written corner sequences and
// randomized traffic compared every cycle against a behavioural model.
module tb_dual_count_monitor;

    localparam int P_IDLE  = 0;
    localparam int P_SYNC  = 1;
    localparam int P_TRACK = 2;
    localparam int P_FAULT = 3;

    logic        clk = 1'b0;
    logic        reset, en, clear, evt_ready;
    logic [7:0]  q0, q1;
    logic        locked, err, evt_valid, evt_ovf;
    logic [2:0]  evt_code;
    logic [7:0]  evt_value;
    logic [15:0] wrap_count;

    always #5 clk = ~clk;

    dual_count_monitor #(.WIDTH(8), .WRAP_CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .q0         (q0),
        .q1         (q1),
        .clear      (clear),
        .locked     (locked),
        .err        (err),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_value  (evt_value),
        .evt_ovf    (evt_ovf),
        .wrap_count (wrap_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Behavioural model: phase, expected count, flags and an event queue of depth one.
    typedef struct {
        int code;
        int value;
    } ev_t;

    int  m_phase, m_exp, m_wraps;
    bit  m_err, m_ovf, m_fresh;
    ev_t evq[$];

    task automatic model_edge(input bit rst, input bit e, input int a, input int b,
                              input bit clr, input bit rdy);
        bit  have_ev;
        bit  pop;
        int  bad;
        ev_t ev;
        if (rst) begin
            m_phase = P_IDLE; m_exp = 0; m_err = 0; m_ovf = 0; m_wraps = 0;
            evq.delete();
            m_fresh = 1;
            return;
        end
        m_fresh = 0;
        have_ev = 0;
        ev.code = 0;
        ev.value = 0;
        pop = (evq.size() != 0) && rdy;
        if (clr && m_phase != P_IDLE) begin
            m_phase = P_SYNC;
        end else if (m_phase == P_IDLE) begin
            m_phase = P_SYNC;
        end else if (m_phase == P_SYNC) begin
            if (a != b) begin
                have_ev = 1; ev.code = 3; ev.value = m_exp;
                m_err = 1; m_phase = P_FAULT;
            end else begin
                m_exp = (a + e) % 256;
                m_phase = P_TRACK;
            end
        end else if (m_phase == P_TRACK) begin
            bad = (a != m_exp ? 1 : 0) + (b != m_exp ? 2 : 0);
            if (bad != 0) begin
                have_ev = 1; ev.code = bad; ev.value = m_exp;
                m_err = 1; m_phase = P_FAULT;
            end else if (e && m_exp == 255) begin
                have_ev = 1; ev.code = 4; ev.value = 255;
                if (m_wraps < 65535) m_wraps++;
            end
            m_exp = (m_exp + e) % 256;
        end
        if (clr) begin
            m_err = 0; m_ovf = 0; m_wraps = 0;
        end
        if (have_ev) begin
            if (evq.size() == 0 || pop) begin
                evq.delete();
                evq.push_back(ev);
            end else begin
                m_ovf = 1;
            end
        end else if (pop) begin
            evq.delete();
        end
    endtask

    task automatic check_all();
        int exp_wc;
`ifdef DCM_WRAP_CNT_EN
        exp_wc = m_wraps;
`else
        exp_wc = 0;
`endif
        chk("locked", locked, (m_phase == P_TRACK) ? 1 : 0);
        chk("err", err, m_err);
        chk("evt_valid", evt_valid, (evq.size() != 0) ? 1 : 0);
        chk("evt_ovf", evt_ovf, m_ovf);
        chk("wrap_count", wrap_count, exp_wc);
        if (evq.size() != 0) begin
            chk("evt_code", evt_code, evq[0].code);
            chk("evt_value", evt_value, evq[0].value);
        end else if (m_fresh) begin
            chk("evt_code_rst", evt_code, 0);
            chk("evt_value_rst", evt_value, 0);
        end
    endtask

    task automatic step(input bit rst, input bit e, input int a, input int b,
                        input bit clr, input bit rdy);
        reset = rst; en = e; q0 = 8'(a); q1 = 8'(b); clear = clr; evt_ready = rdy;
        @(posedge clk);
        model_edge(rst, e, a & 255, b & 255, clr, rdy);
        #1;
        check_all();
    endtask

    int cq;

    task automatic cstep(input bit e, input bit rdy);
        step(1'b0, e, cq, cq, 1'b0, rdy);
        cq = (cq + e) & 255;
    endtask

    typedef struct {
        bit rst, e;
        int a, b;
        bit clr, rdy;
        bit x_locked, x_err, x_valid;
        int x_code, x_value;
    } vec_t;

    vec_t tbl[13];
    int   wrap_seen;
    int   exp_wc1;
    bit   r_e, r_clr, r_rdy, r_rst;
    int   r_a, r_b, r_sel;

    initial begin
        reset = 1'b1; en = 1'b0; q0 = 8'd0; q1 = 8'd0; clear = 1'b0; evt_ready = 1'b0;
        m_phase = P_IDLE; m_exp = 0; m_wraps = 0; m_err = 0; m_ovf = 0; m_fresh = 1;

        //           rst e  a  b  clr rdy  L  E  V  code val
        tbl[0]  = '{1, 0, 5, 5, 0, 0,   0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 5, 5, 0, 0,   0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 5, 5, 0, 0,   1, 0, 0, 0, 0};
        tbl[3]  = '{0, 1, 5, 5, 0, 0,   1, 0, 0, 0, 0};
        tbl[4]  = '{0, 0, 6, 6, 0, 0,   1, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 6, 7, 0, 0,   0, 1, 1, 2, 6};
        tbl[6]  = '{0, 1, 0, 9, 0, 0,   0, 1, 1, 2, 6};
        tbl[7]  = '{0, 0, 3, 3, 1, 0,   0, 0, 1, 2, 6};
        tbl[8]  = '{0, 0, 3, 3, 0, 1,   1, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 2, 3, 0, 0,   0, 1, 1, 1, 3};
        tbl[10] = '{0, 0, 4, 5, 1, 1,   0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 4, 5, 0, 0,   0, 1, 1, 3, 3};
        tbl[12] = '{0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].e, tbl[i].a, tbl[i].b, tbl[i].clr, tbl[i].rdy);
            chk("tbl_locked", locked, tbl[i].x_locked);
            chk("tbl_err", err, tbl[i].x_err);
            chk("tbl_valid", evt_valid, tbl[i].x_valid);
            if (tbl[i].x_valid || tbl[i].rst) begin
                chk("tbl_code", evt_code, tbl[i].x_code);
                chk("tbl_value", evt_value, tbl[i].x_value);
            end
        end

        // Steady tracking from 0x10.
        cq = 8'h10;
        for (int i = 0; i < 20; i++) cstep(1'b1, 1'b1);
        chk("track_locked", locked, 1);
        chk("track_err", err, 0);
        chk("track_valid", evt_valid, 0);

        // Single-cycle q1 glitch, then garbage that must be ignored.
        step(1'b0, 1'b0, cq, cq + 1, 1'b0, 1'b0);
        chk("glitch_err", err, 1);
        chk("glitch_code", evt_code, 2);
        chk("glitch_locked", locked, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
        chk("fault_hold_code", evt_code, 2);
        chk("fault_hold_ovf", evt_ovf, 0);

        // Wrap with ready held high.
        step(1'b0, 1'b0, cq, cq, 1'b1, 1'b1);
        cq = 8'hFC;
        wrap_seen = 0;
        for (int i = 0; i < 8; i++) begin
            cstep(1'b1, 1'b1);
            if (evt_valid && evt_code == 3'd4) begin
                wrap_seen++;
                chk("wrap_value", evt_value, 8'hFF);
            end
        end
        chk("wrap_once", wrap_seen, 1);
`ifdef DCM_WRAP_CNT_EN
        exp_wc1 = 1;
`else
        exp_wc1 = 0;
`endif
        chk("wrap_count_one", wrap_count, exp_wc1);

        // Two wraps with ready low: first held, second dropped.
        step(1'b0, 1'b0, cq, cq, 1'b1, 1'b0);
        cq = 8'hF0;
        for (int i = 0; i < 280; i++) cstep(1'b1, 1'b0);
        chk("ovf_set", evt_ovf, 1);
        chk("ovf_valid", evt_valid, 1);
        chk("ovf_code", evt_code, 4);
        chk("ovf_value", evt_value, 8'hFF);
        step(1'b0, 1'b0, cq, cq, 1'b1, 1'b0);
        chk("clr_ovf", evt_ovf, 0);
        chk("clr_keeps_valid", evt_valid, 1);
        chk("clr_wrap_count", wrap_count, 0);

        // Reset mid-track with an event pending, then resync.
        cstep(1'b0, 1'b0);
        chk("pre_rst_locked", locked, 1);
        step(1'b1, 1'b0, cq, cq, 1'b0, 1'b0);
        chk("rst_locked", locked, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_code", evt_code, 0);
        chk("rst_value", evt_value, 0);
        chk("rst_ovf", evt_ovf, 0);
        step(1'b0, 1'b0, cq, cq, 1'b0, 1'b0);
        cstep(1'b1, 1'b0);
        chk("resync_locked", locked, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r_e   = 1'($urandom_range(0, 1));
            r_a   = cq;
            r_b   = cq;
            r_sel = $urandom_range(0, 99);
            if (r_sel < 2) r_a = $urandom_range(0, 255);
            else if (r_sel < 4) r_b = $urandom_range(0, 255);
            else if (r_sel < 5) begin
                r_a = $urandom_range(0, 255);
                r_b = $urandom_range(0, 255);
            end
            r_clr = ($urandom_range(0, 39) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            r_rst = ($urandom_range(0, 599) == 0);
            step(r_rst, r_e, r_a, r_b, r_clr, r_rdy);
            cq = (cq + r_e) & 255;
            if (r_sel == 99) cq = $urandom_range(0, 255);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
